// File: rtl/filtered_pixel_buffer.sv
// Elastic FWFT output stage for filtered {A,R,G,B} pixels: valid/ready on both sides,
// in-order storage, and a consumed-pixel counter that pulses frame_done at end of frame.
module filtered_pixel_buffer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FRAME_PIXELS = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [31:0]              in_pixel,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pixel,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned FCW = $clog2(FRAME_PIXELS) + 1;

  logic [31:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [FCW-1:0] r_pix_cnt;
  logic           r_frame_done;

  logic w_wr;
  logic w_rd;
  logic w_last;

  // Flags come only from the registered count: no pass-through when full, no bypass when empty.
  assign in_ready   = (r_count != CW'(DEPTH));
  assign out_valid  = (r_count != '0);
  assign out_pixel  = r_mem[r_rptr];
  assign frame_done = r_frame_done;
  assign count      = r_count;

  assign w_wr   = in_valid && in_ready && !clear;
  assign w_rd   = out_valid && out_ready && !clear;
  assign w_last = (r_pix_cnt == FCW'(FRAME_PIXELS - 1));

  // Storage needs no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_rd) begin
        r_pix_cnt <= w_last ? '0 : r_pix_cnt + FCW'(1);
      end
      r_frame_done <= w_rd && w_last;
    end
  end

endmodule

// File: tb/tb_filtered_pixel_buffer.sv
// Directed bench for filtered_pixel_buffer: a vector table for fill/back-pressure/drain and
// hand-written sequences for simultaneous access, frame pulses, clear and async reset.
module tb_filtered_pixel_buffer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pixel = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pixel;
  logic        out_ready = 1'b0;
  logic        frame_done;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  int          mcnt = 0;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [31:0] pix;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pix;
    logic        e_pix_care;
    logic [3:0]  e_cnt;
    logic        e_fd;
  } vec_t;

  vec_t        tbl[19];
  logic [31:0] p[9];

  filtered_pixel_buffer #(.DEPTH(8), .FRAME_PIXELS(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; expectations come from a queue model of the FIFO and frame counter.
  task automatic mstep(input logic clr, input logic iv, input logic [31:0] pix, input logic ordy,
                       input string tag);
    logic do_w, do_r, efd;
    do_w = iv && (q.size() != 8) && !clr;
    do_r = ordy && (q.size() != 0) && !clr;
    @(negedge clk);
    clear = clr; in_valid = iv; in_pixel = pix; out_ready = ordy;
    @(posedge clk);
    #1;
    efd = 1'b0;
    if (clr) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (do_r) begin
        void'(q.pop_front());
        if (mcnt == 15) begin
          mcnt = 0;
          efd  = 1'b1;
        end else begin
          mcnt++;
        end
      end
      if (do_w) q.push_back(pix);
    end
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() != 8));
    check({tag, "_frame_done"}, 32'(frame_done), 32'(efd));
    if (q.size() != 0) check({tag, "_out_pixel"}, out_pixel, q[0]);
  endtask

  task automatic idle();
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Continuous stream from empty: n pixels offered, consumer always ready.
  task automatic stream(input int n, input int cycles, input logic [31:0] base, input string tag);
    for (int t = 0; t < cycles; t++) begin
      mstep(1'b0, t < n, base + 32'(t), 1'b1, tag);
      check({tag, "_pulse_pos"}, 32'(frame_done), 32'((t > 0) && (t <= n) && (t % 16 == 0)));
    end
  endtask

  initial begin
    p[0] = 32'hFF101010; p[1] = 32'hFFFF31B4; p[2] = 32'h80402010; p[3] = 32'h00000000;
    p[4] = 32'hFFFFFFFF; p[5] = 32'h12345678; p[6] = 32'hDEADBEEF; p[7] = 32'h0A0B0C0D;
    p[8] = 32'hCAFEF00D;

    // Fill with consumer stalled, then two rejected offers of a 9th pixel.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b0, 1'b1, p[i], 1'b0, (i < 7), 1'b1, p[0], 1'b1, 4'(i + 1), 1'b0};
    tbl[8] = '{1'b0, 1'b1, p[8], 1'b0, 1'b0, 1'b1, p[0], 1'b1, 4'd8, 1'b0};
    tbl[9] = '{1'b0, 1'b1, p[8], 1'b0, 1'b0, 1'b1, p[0], 1'b1, 4'd8, 1'b0};
    // Drain in order, then a read attempt while empty.
    for (int j = 0; j < 8; j++)
      tbl[10 + j] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, (j < 7), (j < 7) ? p[j + 1] : 32'h0,
                      (j < 7), 4'(7 - j), 1'b0};
    tbl[18] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};

    // Async reset asserted mid-cycle takes effect without a clock edge.
    #13;
    n_rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      clear = tbl[i].clr; in_valid = tbl[i].iv; in_pixel = tbl[i].pix; out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].e_fd));
      if (tbl[i].e_pix_care)
        check($sformatf("tbl%0d_out_pixel", i), out_pixel, tbl[i].e_pix);
    end

    // Steady simultaneous read/write at count 3.
    mstep(1'b1, 1'b0, 32'h0, 1'b0, "clrA");
    for (int i = 0; i < 3; i++) mstep(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, "fillA");
    for (int i = 0; i < 10; i++) begin
      mstep(1'b0, 1'b1, 32'hA100_0000 + 32'(i), 1'b1, "rwA");
      check("rwA_count3", 32'(count), 32'd3);
    end

    // Simultaneous read/write while full: the write is refused.
    mstep(1'b1, 1'b0, 32'h0, 1'b0, "clrB");
    for (int i = 0; i < 8; i++) mstep(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, "fillB");
    mstep(1'b0, 1'b1, 32'hBBBB_BBBB, 1'b1, "rwfullB");
    check("rwfullB_count7", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) mstep(1'b0, 1'b0, 32'h0, 1'b1, "drainB");
    check("drainB_last_empty", 32'(out_valid), 32'd0);

    // Two frames streamed back to back: pulses after reads 16 and 32 only.
    mstep(1'b1, 1'b0, 32'h0, 1'b0, "clrC");
    stream(32, 34, 32'hC000_0000, "frameC");

    // Clear mid-frame with handshakes active: counter restarts from zero.
    mstep(1'b1, 1'b0, 32'h0, 1'b0, "clrD0");
    for (int i = 0; i < 5; i++) mstep(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, "fillD");
    for (int i = 0; i < 9; i++) mstep(1'b0, 1'b1, 32'hD100_0000 + 32'(i), 1'b1, "rwD");
    check("preclrD_count5", 32'(count), 32'd5);
    mstep(1'b1, 1'b1, 32'hDDDD_DDDD, 1'b1, "clrD");
    check("clrD_count0", 32'(count), 32'd0);
    check("clrD_out_valid0", 32'(out_valid), 32'd0);
    stream(16, 18, 32'hD200_0000, "frameD");

    // Async reset while holding data discards everything.
    for (int i = 0; i < 3; i++) mstep(1'b0, 1'b1, 32'hE000_0000 + 32'(i), 1'b0, "fillE");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    q.delete();
    mcnt = 0;
    check("rstE_count", 32'(count), 32'd0);
    check("rstE_out_valid", 32'(out_valid), 32'd0);
    check("rstE_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    mstep(1'b0, 1'b1, 32'h5EED_1234, 1'b0, "postE");
    mstep(1'b0, 1'b0, 32'h0, 1'b1, "postE_rd");
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
